// File: rtl/slt_iter_compare_unit_if.sv
// Handshake and operand bundle for the iterative set-on-less-than / compare unit.
// The master issues start/op/a/b; the slave answers with busy/done/result.
interface slt_iter_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start,
    output op,
    output a,
    output b,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  op,
    input  a,
    input  b,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/slt_iter_compare_unit.sv
// Multi-cycle SLT/SLTU/SEQ/SNE unit comparing CHUNK bits per cycle, MSB chunk first.
// Define SLT_EARLY_EXIT_EN to stop at the first differing chunk instead of walking all chunks.
module slt_iter_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  slt_iter_compare_unit_if.slave cmp
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    LAST_IDX  = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SNE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

  stateT            stateReg, stateNext;
  logic [WIDTH-1:0] aReg, aNext;
  logic [WIDTH-1:0] bReg, bNext;
  logic [1:0]       opReg, opNext;
  logic [CW-1:0]    cntReg, cntNext;
  logic             flagReg, flagNext;
`ifndef SLT_EARLY_EXIT_EN
  logic             hitReg, hitNext;
  logic             hitFlagReg, hitFlagNext;
`endif

  // Operands split into chunk lanes; lane NCHUNK-1 holds the MSBs.
  logic [CHUNK-1:0] aChunk [NCHUNK];
  logic [CHUNK-1:0] bChunk [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : gChunk
    assign aChunk[gi] = aReg[gi*CHUNK +: CHUNK];
    assign bChunk[gi] = bReg[gi*CHUNK +: CHUNK];
  end

  logic [CW-1:0]    chunkSel;
  logic [CHUNK-1:0] curA;
  logic [CHUNK-1:0] curB;
  logic             chunkDiffer;
  logic             chunkLess;
  logic             diffFlag;
  logic             eqFlag;
  logic             lastChunk;

  assign chunkSel    = LAST_IDX - cntReg;
  assign curA        = aChunk[chunkSel];
  assign curB        = bChunk[chunkSel];
  assign chunkDiffer = (curA != curB);
  assign chunkLess   = (curA < curB);
  assign lastChunk   = (cntReg == LAST_IDX);
  assign eqFlag      = (opReg == OP_SEQ);

  // Flag value once a difference is known; SLT operands are already offset-binary.
  always_comb begin
    diffFlag = 1'b0;
    case (opReg)
      OP_SLT, OP_SLTU: diffFlag = chunkLess;
      OP_SEQ:          diffFlag = 1'b0;
      OP_SNE:          diffFlag = 1'b1;
      default:         diffFlag = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      aReg       <= '0;
      bReg       <= '0;
      opReg      <= '0;
      cntReg     <= '0;
      flagReg    <= 1'b0;
`ifndef SLT_EARLY_EXIT_EN
      hitReg     <= 1'b0;
      hitFlagReg <= 1'b0;
`endif
    end else begin
      stateReg   <= stateNext;
      aReg       <= aNext;
      bReg       <= bNext;
      opReg      <= opNext;
      cntReg     <= cntNext;
      flagReg    <= flagNext;
`ifndef SLT_EARLY_EXIT_EN
      hitReg     <= hitNext;
      hitFlagReg <= hitFlagNext;
`endif
    end
  end

  always_comb begin
    stateNext   = stateReg;
    aNext       = aReg;
    bNext       = bReg;
    opNext      = opReg;
    cntNext     = cntReg;
    flagNext    = flagReg;
`ifndef SLT_EARLY_EXIT_EN
    hitNext     = hitReg;
    hitFlagNext = hitFlagReg;
`endif
    case (stateReg)
      IDLE, DONE: begin
        if (cmp.start) begin
          stateNext = RUN;
          // Flipping the sign bit maps two's complement order onto unsigned order.
          aNext     = (cmp.op == OP_SLT) ? (cmp.a ^ SIGN_MASK) : cmp.a;
          bNext     = (cmp.op == OP_SLT) ? (cmp.b ^ SIGN_MASK) : cmp.b;
          opNext    = cmp.op;
          cntNext   = '0;
`ifndef SLT_EARLY_EXIT_EN
          hitNext     = 1'b0;
          hitFlagNext = 1'b0;
`endif
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
`ifdef SLT_EARLY_EXIT_EN
        if (chunkDiffer) begin
          stateNext = DONE;
          flagNext  = diffFlag;
        end else if (lastChunk) begin
          stateNext = DONE;
          flagNext  = eqFlag;
        end else begin
          cntNext = cntReg + 1'b1;
        end
`else
        // Only the most significant differing chunk decides the outcome.
        if (!hitReg && chunkDiffer) begin
          hitNext     = 1'b1;
          hitFlagNext = diffFlag;
        end
        if (lastChunk) begin
          stateNext = DONE;
          flagNext  = hitReg ? hitFlagReg : (chunkDiffer ? diffFlag : eqFlag);
        end else begin
          cntNext = cntReg + 1'b1;
        end
`endif
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign cmp.busy   = (stateReg == RUN);
  assign cmp.done   = (stateReg == DONE);
  assign cmp.result = WIDTH'(flagReg);

endmodule

// File: tb/tb_slt_iter_compare_unit.sv
// Directed self-checking bench for slt_iter_compare_unit (WIDTH=32, CHUNK=8).
module tb_slt_iter_compare_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  int   lat;
  int   doneSeen;

  slt_iter_compare_unit_if #(.WIDTH(WIDTH)) cmpIf ();

  slt_iter_compare_unit #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .cmp (cmpIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int expLat(input int earlyLat);
`ifdef SLT_EARLY_EXIT_EN
    return earlyLat;
`else
    return 4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Count cycles (from the cycle after the accepting edge) until done, bounded.
  task automatic waitDone(input int lat0, output int latOut);
    int l;
    l = lat0;
    while (cmpIf.done !== 1'b1 && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    latOut = l;
  endtask

  task automatic doOp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [1:0] opv, input logic [31:0] expRes, input int expL);
    int l;
    @(negedge clk);
    cmpIf.start = 1'b1;
    cmpIf.a     = av;
    cmpIf.b     = bv;
    cmpIf.op    = opv;
    @(posedge clk);
    #1;
    cmpIf.start = 1'b0;
    chk({tag, " busy"}, 64'(cmpIf.busy), 64'd1);
    waitDone(0, l);
    chk({tag, " latency"}, 64'(l), 64'(expL));
    chk({tag, " result"}, 64'(cmpIf.result), 64'(expRes));
    $display("op %s a=%08h b=%08h op=%0d result=%0h latency=%0d", tag, av, bv, opv, cmpIf.result, l);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst = 1'b1;
    cmpIf.start = 1'b0;
    cmpIf.op    = 2'b00;
    cmpIf.a     = '0;
    cmpIf.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(cmpIf.busy), 64'd0);
    chk("reset done", 64'(cmpIf.done), 64'd0);
    chk("reset result", 64'(cmpIf.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    doOp("slt_neg1_vs_1",   32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'd1, expLat(1));
    doOp("sltu_max_vs_1",   32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'd0, expLat(1));
    doOp("slt_min_vs_max",  32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 32'd1, expLat(1));
    doOp("sltu_min_vs_max", 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 32'd0, expLat(1));
    doOp("sltu_lowchunk",   32'h1234_5678, 32'h1234_5679, 2'b01, 32'd1, 4);
    doOp("seq_lowchunk",    32'h1234_5678, 32'h1234_5679, 2'b10, 32'd0, 4);
    doOp("sne_lowchunk",    32'h1234_5678, 32'h1234_5679, 2'b11, 32'd1, 4);
    doOp("seq_equal",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 32'd1, 4);
    doOp("sne_equal",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 32'd0, 4);
    doOp("slt_equal",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 32'd0, 4);
    doOp("sltu_topchunk",   32'h0100_0000, 32'h0200_0000, 2'b01, 32'd1, expLat(1));

    // Start during RUN is ignored.
    @(negedge clk);
    cmpIf.start = 1'b1;
    cmpIf.a = 32'd5;
    cmpIf.b = 32'd9;
    cmpIf.op = 2'b00;
    @(posedge clk);
    #1;
    cmpIf.a = 32'd9;
    cmpIf.b = 32'd5;
    cmpIf.op = 2'b01;
    @(posedge clk);
    #1;
    cmpIf.start = 1'b0;
    chk("ignored start busy", 64'(cmpIf.busy), 64'd1);
    waitDone(1, lat);
    chk("ignored start latency", 64'(lat), 64'd4);
    chk("ignored start result", 64'(cmpIf.result), 64'd1);
    $display("op ignore_start a=5 b=9 op=0 result=%0h latency=%0d", cmpIf.result, lat);

    // Back-to-back issue from the DONE cycle.
    cmpIf.start = 1'b1;
    cmpIf.a = 32'd9;
    cmpIf.b = 32'd5;
    cmpIf.op = 2'b00;
    @(posedge clk);
    #1;
    cmpIf.start = 1'b0;
    chk("b2b busy", 64'(cmpIf.busy), 64'd1);
    chk("b2b done low", 64'(cmpIf.done), 64'd0);
    chk("b2b result held", 64'(cmpIf.result), 64'd1);
    waitDone(0, lat);
    chk("b2b latency", 64'(lat), 64'd4);
    chk("b2b result", 64'(cmpIf.result), 64'd0);
    $display("op back_to_back a=9 b=5 op=0 result=%0h latency=%0d", cmpIf.result, lat);

    // Leave result=1, then abort an operation with reset in its 2nd RUN cycle.
    doOp("sne_before_abort", 32'h0000_0001, 32'h0000_0002, 2'b11, 32'd1, 4);
    @(negedge clk);
    cmpIf.start = 1'b1;
    cmpIf.a = 32'h0000_0001;
    cmpIf.b = 32'h0000_0002;
    cmpIf.op = 2'b01;
    @(posedge clk);
    #1;
    cmpIf.start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort running", 64'(cmpIf.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", 64'(cmpIf.busy), 64'd0);
    chk("abort done", 64'(cmpIf.done), 64'd0);
    chk("abort result", 64'(cmpIf.result), 64'd0);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (cmpIf.done === 1'b1) doneSeen++;
    end
    chk("abort no done", 64'(doneSeen), 64'd0);
    $display("op reset_abort busy=%0b done_pulses=%0d result=%0h", cmpIf.busy, doneSeen, cmpIf.result);

    doOp("slt_after_abort", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b00, 32'd1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
